// File: rtl/poly_operand_feeder.sv
// -----------------------------------------------------------------------------
// poly_operand_feeder
//
// Upstream driver for the polynomial datapath. On an accepted start pulse it
// captures four operands (A, B, C, X) and presents them one at a time on
// data_out. Each operand is first shown with go low for GAP_CYCLES cycles,
// then strobed with go high for HOLD_CYCLES cycles. This matches the
// press/release pattern the datapath load states expect. After the last
// release it waits RESULT_WAIT cycles, captures result_in and pulses done.
//
// Handshake: start is a level that is sampled on every rising edge but acts
// only in IDLE. Starts seen in any other state are dropped, not queued.
// busy is high from the accepted start up to the capture edge. done is a
// single-cycle pulse in the cycle after capture, and busy is already low in
// that cycle. A start during the done cycle is accepted.
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset (shared with the datapath)
//   start      in   request a run (accepted in IDLE only)
//   a_in..x_in in   operands, captured on the accepted start edge
//   result_in  in   datapath result register
//   go         out  registered go strobe to the datapath
//   data_out   out  registered operand to the datapath
//   busy       out  run in progress
//   done       out  one-cycle pulse after the result is captured
//   result     out  last captured result
//   state_dbg  out  current FSM state (IDLE=0, PRESENT=1, STROBE=2, SETTLE=3)
// -----------------------------------------------------------------------------
module poly_operand_feeder #(
  parameter int DATA_W      = 8,
  parameter int GAP_CYCLES  = 1,
  parameter int HOLD_CYCLES = 2,
  parameter int RESULT_WAIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] c_in,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] result_in,
  output logic              go,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        state_dbg
);

  // The counter only has to reach the longest phase length minus one.
  localparam int MAX_GH = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_GH > RESULT_WAIT) ? MAX_GH : RESULT_WAIT;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_STROBE  = 2'd2,
    S_SETTLE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] op_q [4];
  logic              load_ops;

  logic              go_q, go_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic gap_end, hold_end, wait_end;

  assign gap_end  = (cnt_q == CNT_W'(GAP_CYCLES - 1));
  assign hold_end = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  assign wait_end = (cnt_q == CNT_W'(RESULT_WAIT - 1));
  assign idx_inc  = idx_q + 2'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start)    state_d = S_PRESENT;
      S_PRESENT: if (gap_end)  state_d = S_STROBE;
      S_STROBE:  if (hold_end) state_d = (idx_q == 2'd3) ? S_SETTLE : S_PRESENT;
      S_SETTLE:  if (wait_end) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values. Every output is registered. data_out is
  // only reloaded on the edge that lowers go, or on the IDLE->PRESENT edge,
  // so the datapath never sees the operand change while go is high.
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d    = idx_q;
    cnt_d    = cnt_q + CNT_W'(1);
    go_d     = go_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    load_ops = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        go_d  = 1'b0;
        if (start) begin
          load_ops = 1'b1;
          idx_d    = 2'd0;
          data_d   = a_in;
          busy_d   = 1'b1;
        end
      end
      S_PRESENT: begin
        if (gap_end) begin
          go_d  = 1'b1;
          cnt_d = '0;
        end
      end
      S_STROBE: begin
        if (hold_end) begin
          go_d  = 1'b0;
          cnt_d = '0;
          if (idx_q != 2'd3) begin
            idx_d  = idx_inc;
            data_d = op_q[idx_inc];
          end
        end
      end
      S_SETTLE: begin
        if (wait_end) begin
          result_d = result_in;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
        end
      end
      default: begin
        cnt_d = '0;
        go_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      go_q     <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      for (int k = 0; k < 4; k++) op_q[k] <= '0;
    end else begin
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      go_q     <= go_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      if (load_ops) begin
        op_q[0] <= a_in;
        op_q[1] <= b_in;
        op_q[2] <= c_in;
        op_q[3] <= x_in;
      end
    end
  end

  assign go        = go_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_poly_operand_feeder.sv
// -----------------------------------------------------------------------------
// tb_poly_operand_feeder
//
// Two feeders share clk/resetn. Instance 0 uses the default timing
// (GAP=1, HOLD=2, WAIT=4). Instance 1 uses GAP=1, HOLD=1, WAIT=4.
// Each feeder drives a small behavioural datapath. That datapath latches the
// operand present during the 1st and 3rd go pulses. Three edges after the
// 4th release it loads A*A+C into its result register.
//
// The driver decides from the start times alone whether a start is accepted.
// For each accepted start it pushes the expected operands, the go rise edges,
// the capture edge and the expected result into the scoreboard queues. The
// monitor pops and compares those entries whenever the DUT raises go or done.
// -----------------------------------------------------------------------------
module tb_poly_operand_feeder;

  localparam int G0 = 1, H0 = 2, R0 = 4;
  localparam int G1 = 1, H1 = 1, R1 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- DUT wiring ----------------
  logic       start_v [2];
  logic [7:0] a_v [2], b_v [2], c_v [2], x_v [2], res_in [2];
  logic       go_w [2], busy_w [2], done_w [2];
  logic [7:0] dout_w [2], result_w [2];
  logic [1:0] st_w [2];

  poly_operand_feeder #(.DATA_W(8), .GAP_CYCLES(G0), .HOLD_CYCLES(H0), .RESULT_WAIT(R0)) dut0 (
    .clk(clk), .resetn(resetn), .start(start_v[0]),
    .a_in(a_v[0]), .b_in(b_v[0]), .c_in(c_v[0]), .x_in(x_v[0]), .result_in(res_in[0]),
    .go(go_w[0]), .data_out(dout_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .result(result_w[0]), .state_dbg(st_w[0])
  );

  poly_operand_feeder #(.DATA_W(8), .GAP_CYCLES(G1), .HOLD_CYCLES(H1), .RESULT_WAIT(R1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start_v[1]),
    .a_in(a_v[1]), .b_in(b_v[1]), .c_in(c_v[1]), .x_in(x_v[1]), .result_in(res_in[1]),
    .go(go_w[1]), .data_out(dout_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .result(result_w[1]), .state_dbg(st_w[1])
  );

  function automatic int gap_of(input int i);  return (i == 0) ? G0 : G1; endfunction
  function automatic int hold_of(input int i); return (i == 0) ? H0 : H1; endfunction
  function automatic int rw_of(input int i);   return (i == 0) ? R0 : R1; endfunction

  // ---------------- behavioural datapath ----------------
  int         dp_rel [2];
  int         dp_wait [2];
  logic       dp_prev_go [2];
  logic [7:0] dp_a [2], dp_c [2];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        dp_rel[i] <= 0; dp_wait[i] <= 0; dp_prev_go[i] <= 1'b0;
        dp_a[i] <= 8'h00; dp_c[i] <= 8'h00; res_in[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        dp_prev_go[i] <= go_w[i];
        if (go_w[i]) begin
          if (dp_rel[i] == 0) dp_a[i] <= dout_w[i];
          if (dp_rel[i] == 2) dp_c[i] <= dout_w[i];
        end
        if (dp_wait[i] == 2) dp_wait[i] <= 1;
        if (dp_wait[i] == 1) begin
          res_in[i]  <= 8'(dp_a[i] * dp_a[i] + dp_c[i]);
          dp_wait[i] <= 0;
        end
        if (dp_prev_go[i] && !go_w[i]) begin
          if (dp_rel[i] == 3) begin
            dp_rel[i]  <= 0;
            dp_wait[i] <= 2;
          end else begin
            dp_rel[i] <= dp_rel[i] + 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int         inst;
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t op_q[$];
  exp_t done_q[$];
  int   last_cap [2];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input int inst);
    n_cmp++;
    n_fail++;
    $display("FAIL %s inst%0d: event seen, none expected (edge %0d)", name, inst, edge_cnt);
  endtask

  // ---------------- monitor ----------------
  logic       mp_go [2];
  logic [7:0] mp_d [2];
  int         rise_e [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        mp_go[i] <= 1'b0;
        mp_d[i]  <= 8'h00;
      end else begin : mon_i
        int idx;
        if (go_w[i] && !mp_go[i]) begin
          idx = -1;
          foreach (op_q[j]) if (idx < 0 && op_q[j].inst == i) idx = j;
          if (idx < 0) unexpected("go_rise", i);
          else begin
            chk("operand", i, dout_w[i], op_q[idx].val);
            chk("go_rise_edge", i, edge_cnt, op_q[idx].cyc);
            op_q.delete(idx);
          end
          rise_e[i] <= edge_cnt;
        end
        if (!go_w[i] && mp_go[i])
          chk("go_width", i, edge_cnt - rise_e[i], hold_of(i));
        if (go_w[i] && mp_go[i])
          chk("data_stable_while_go", i, dout_w[i], mp_d[i]);
        if (done_w[i]) begin
          idx = -1;
          foreach (done_q[j]) if (idx < 0 && done_q[j].inst == i) idx = j;
          if (idx < 0) unexpected("done", i);
          else begin
            chk("result", i, result_w[i], done_q[idx].val);
            chk("done_edge", i, edge_cnt, done_q[idx].cyc);
            chk("busy_in_done", i, busy_w[i], 1'b0);
            done_q.delete(idx);
          end
        end
        mp_go[i] <= go_w[i];
        mp_d[i]  <= dout_w[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; the start is seen by the next rising edge.
  task automatic issue(input int i, input logic [7:0] a, b, c, x, output int t0);
    int e, p;
    logic [7:0] ops [4];
    ops[0] = a; ops[1] = b; ops[2] = c; ops[3] = x;
    a_v[i] = a; b_v[i] = b; c_v[i] = c; x_v[i] = x;
    start_v[i] = 1'b1;
    e  = edge_cnt + 1;
    t0 = -1;
    if (e > last_cap[i]) begin
      p  = gap_of(i) + hold_of(i);
      t0 = e;
      for (int k = 0; k < 4; k++)
        op_q.push_back('{inst: i, cyc: e + k * p + gap_of(i), val: ops[k]});
      last_cap[i] = e + 4 * p + rw_of(i);
      done_q.push_back('{inst: i, cyc: last_cap[i], val: 8'(a * a + c)});
    end
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_until(input int e);
    int budget = 500;
    while (edge_cnt < e && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) unexpected("wait_until_timeout", 0);
  endtask

  task automatic drain();
    int budget = 400;
    while ((op_q.size() != 0 || done_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d operands and %0d results outstanding, expected 0",
               op_q.size(), done_q.size());
      op_q.delete();
      done_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero();
    for (int i = 0; i < 2; i++) begin
      chk("rst_go", i, go_w[i], 1'b0);
      chk("rst_busy", i, busy_w[i], 1'b0);
      chk("rst_done", i, done_w[i], 1'b0);
      chk("rst_data_out", i, dout_w[i], 8'h00);
      chk("rst_result", i, result_w[i], 8'h00);
    end
  endtask

  function automatic logic [7:0] r8();
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    int t0, tx;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      a_v[i] = 8'h00; b_v[i] = 8'h00; c_v[i] = 8'h00; x_v[i] = 8'h00;
      last_cap[i] = -1;
    end
    resetn = 1'b1;
    #3 resetn = 1'b0;
    #1 check_zero();
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);

    // Basic run with the default timing.
    issue(0, 8'd3, 8'd0, 8'd5, 8'd0, t0);
    drain();
    issue(0, 8'd20, 8'd7, 8'd100, 8'd9, t0);
    drain();

    // Extra starts are ignored and late operand changes do not leak in.
    issue(0, r8(), r8(), r8(), r8(), t0);
    wait_until(t0 + 1);
    a_v[0] = r8(); b_v[0] = r8(); c_v[0] = r8(); x_v[0] = r8();
    wait_until(t0 + 4);
    issue(0, r8(), r8(), r8(), r8(), tx);
    chk("start_ignored_t5", 0, tx, -1);
    wait_until(t0 + 13);
    issue(0, r8(), r8(), r8(), r8(), tx);
    chk("start_ignored_t14", 0, tx, -1);
    drain();

    // Reset while go is high for operand C.
    issue(0, r8(), r8(), r8(), r8(), t0);
    wait_until(t0 + 2 * (G0 + H0) + G0);
    chk("go_high_before_reset", 0, go_w[0], 1'b1);
    #2 resetn = 1'b0;
    #1 check_zero();
    op_q.delete();
    done_q.delete();
    last_cap[0] = -1;
    last_cap[1] = -1;
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    issue(0, 8'd4, r8(), 8'd1, r8(), t0);
    drain();

    // Short timing: wraps to zero, then a start during the done cycle.
    issue(1, 8'd15, r8(), 8'd31, r8(), t0);
    wait_until(last_cap[1]);
    chk("done_cycle_reached", 1, done_w[1], 1'b1);
    issue(1, r8(), r8(), r8(), r8(), tx);
    chk("start_in_done_accepted", 1, tx, t0 + 4 * (G1 + H1) + R1 + 1);
    drain();

    // Random starts on both instances; the model decides acceptance.
    repeat (40) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      issue($urandom_range(0, 1), r8(), r8(), r8(), r8(), tx);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_operand_feeder.md
# poly_operand_feeder

Upstream driver for the polynomial datapath. It captures four 8-bit operands (A, B, C, X) on a single start pulse and presents them to the datapath's `data_in`/`go` pair one at a time, using the press/release protocol the datapath's load states expect. It waits a fixed settle time, captures the datapath's registered result and pulses `done`. The block replaces manual SW/KEY operation when the datapath is exercised by on-chip logic.

## Interface
- `DATA_W`, default 8: operand and result width.
- `GAP_CYCLES`, default 1: cycles `go` is held low with a new operand on `data_out` before it is strobed. Minimum 1.
- `HOLD_CYCLES`, default 2: cycles `go` is held high per operand. Minimum 1.
- `RESULT_WAIT`, default 4: cycles from the final `go` release to result capture. Minimum 4.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset is asynchronous and active-low. It is driven from the same net as the datapath's reset.
- `start` in 1: sampled each edge; accepted only in IDLE.
- `a_in`, `b_in`, `c_in`, `x_in` in `DATA_W` each: operands, captured on the accepted `start` edge.
- `result_in` in `DATA_W`: datapath result register output.
- `go` out 1: registered; drives the datapath go input, active-high.
- `data_out` out `DATA_W`: registered; drives the datapath data input.
- `busy` out 1: high from the accepted start until capture.
- `done` out 1: one-cycle pulse after capture.
- `result` out `DATA_W`: last captured result; held until the next capture.

## Operation
- Reset (asynchronous, `resetn`=0):
  - State returns to IDLE.
  - `go`, `busy` and `done` go to 0.
  - `data_out`, `result`, the operand registers, the index and the counter go to 0.
- States:
  - IDLE: `go`=0, `busy`=0. When `start`=1, capture the four operands, set idx=0 and the counter to 0, then go to PRESENT.
  - PRESENT: `go`=0 and `data_out`=op[idx]. After `GAP_CYCLES` cycles, go to STROBE.
  - STROBE: `go`=1 and `data_out`=op[idx] is held. After `HOLD_CYCLES` cycles:
    - if idx=3, go to SETTLE;
    - otherwise idx+1, then PRESENT.
  - SETTLE: `go`=0 and `data_out` holds X. On the edge ending the `RESULT_WAIT`-th cycle:
    - `result` <= `result_in`;
    - `done` <= 1 for one cycle;
    - `busy` <= 0;
    - return to IDLE.
- Operand order is fixed: op[0..3] = A, B, C, X.
- `data_out` changes only on the same edge that lowers `go`, or on the edge that enters PRESENT from IDLE. It never changes while `go`=1.
- `start` in any non-IDLE state is ignored; no queuing.
- Changes on `a_in`..`x_in` after capture do not affect the run in progress.
- `start`=1 during the `done` cycle (state is IDLE) is accepted.
- The datapath returns (A*A + C) mod 2^`DATA_W`. B and X are loaded but unused. This block does not compute or check the value.
- No arithmetic in this block.
- Counters are sized for max(`GAP_CYCLES`, `HOLD_CYCLES`, `RESULT_WAIT`) and do not wrap within a legal run.

## Timing
Let T0 be the edge where `start` is accepted, and P = `GAP_CYCLES` + `HOLD_CYCLES`.

- Operand k (k = 0..3):
  - `data_out` is valid from T0 + k·P;
  - `go` rises at T0 + k·P + `GAP_CYCLES`;
  - `go` falls at T0 + (k+1)·P.
- Last `go` fall: T0 + 4P. The datapath's result register is loaded at T0 + 4P + 3. The default `RESULT_WAIT`=4 therefore captures one cycle after the result is valid.
- Capture edge: T0 + 4P + `RESULT_WAIT`. `done` is high for the following cycle, during which `busy`=0.
- Defaults: P=3, so capture is at T0+16, with `go` high at T1–T3, T4–T6, T7–T9 and T10–T12 (edge ranges, rising to falling).
- Reset mid-run: `go` drops asynchronously, so the datapath sees a release. Because both blocks share `resetn`, the datapath also returns to its A-load state. The next `start` runs a complete, correct sequence.

## Test plan
- Default params, A=3, B=0, C=5, X=0, `start` at T0:
  - `data_out` = 3, 0, 5, 0 with four `go` pulses of 2 cycles each;
  - `done` at T0+16 with `result`=0x0E.
- A=20, C=100 (B=7, X=9): `result`=0xF4 (500 mod 256). `done` pulses exactly once and `busy` is 0 in the `done` cycle.
- Apply `start` pulses at T0+5 and T0+14 and change `a_in`..`x_in` at T0+2:
  - the extra starts are ignored;
  - the transmitted operands are the T0 values;
  - exactly one `done`.
- Assert `resetn`=0 while `go`=1 for operand C:
  - `go`, `busy`, `done`, `data_out` and `result` read 0 immediately, before the next edge;
  - after release, a new run with A=4, C=1 yields `result`=0x11.
- `HOLD_CYCLES`=1, `GAP_CYCLES`=1, `RESULT_WAIT`=4:
  - each `go` pulse is 1 cycle and capture is at T0+12;
  - with A=15, C=31, `result`=0x00 (256 mod 256);
  - `start` asserted during the `done` cycle is accepted and the second run completes.
